// File: rtl/fetch_buffer_pkg.sv
// fetch_buffer_pkg: shared instruction-word and buffer-entry types for the fetch path
package fetch_buffer_pkg;

    typedef logic [31:0] rv32i_word;

    typedef struct packed {
        rv32i_word instr;
        rv32i_word pc;
    } fb_entry_t;

    localparam int        FB_DEPTH    = 8;
    localparam rv32i_word FB_RESET_PC = 32'h0000_0060;

    function automatic rv32i_word word_align(input rv32i_word a);
        return {a[31:2], 2'b00};
    endfunction

endpackage

// File: rtl/fetch_buffer_ptr_ctrl.sv
// fb_ptr_ctrl: alloc/fill/head pointers, occupancy, and drop accounting for flushed in-flight responses
module fb_ptr_ctrl #(
    parameter int DEPTH = 8,
    parameter int IW    = $clog2(DEPTH),
    parameter int PW    = $clog2(DEPTH) + 1,
    parameter int DW    = $clog2(DEPTH + 1)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          redirect,
    input  logic          req_fire,
    input  logic          resp_valid,
    input  logic          pop,
    output logic [IW-1:0] alloc_idx,
    output logic [IW-1:0] fill_idx,
    output logic [IW-1:0] head_idx,
    output logic          can_req,
    output logic          has_head,
    output logic          fill_we,
    output logic          resp_err
);

    localparam logic [PW-1:0] ONE = PW'(1);

    logic [PW-1:0] alloc_q, fill_q, head_q;
    logic [PW-1:0] count, outstanding;
    logic [DW-1:0] drop_q, drop_d, in_flight;
    logic          resp_lost;

    assign count       = alloc_q - head_q;
    assign outstanding = alloc_q - fill_q;
    assign alloc_idx   = alloc_q[IW-1:0];
    assign fill_idx    = fill_q[IW-1:0];
    assign head_idx    = head_q[IW-1:0];
    assign can_req     = count < PW'(DEPTH);
    assign has_head    = head_q != fill_q;

    // Route each response: drain pending drops first, then fill, else flag it as unexpected
    always_comb begin
        in_flight = drop_q + DW'(outstanding);
        fill_we   = resp_valid & ~redirect & (drop_q == '0) & (outstanding != '0);
        resp_lost = resp_valid & (redirect ? (in_flight == '0)
                                           : ((drop_q == '0) & (outstanding == '0)));
        drop_d    = redirect ? in_flight - DW'(resp_valid & (in_flight != '0))
                             : drop_q - DW'(resp_valid & (drop_q != '0));
    end

    // Pointer and drop-counter state; a redirect empties the buffer and converts in-flight work to drops
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            alloc_q  <= '0;
            fill_q   <= '0;
            head_q   <= '0;
            drop_q   <= '0;
            resp_err <= 1'b0;
        end else begin
            drop_q <= drop_d;
            if (resp_lost) resp_err <= 1'b1;
            if (redirect) begin
                alloc_q <= '0;
                fill_q  <= '0;
                head_q  <= '0;
            end else begin
                if (req_fire) alloc_q <= alloc_q + ONE;
                if (fill_we)  fill_q  <= fill_q + ONE;
                if (pop)      head_q  <= head_q + ONE;
            end
        end
    end

endmodule

// File: rtl/fetch_buffer.sv
// fetch_buffer: sequential PC generation, I-cache request issue, and in-order instr/pc buffering for decode
module fetch_buffer
    import fetch_buffer_pkg::*;
#(
    parameter int        DEPTH    = FB_DEPTH,
    parameter rv32i_word RESET_PC = FB_RESET_PC
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        req_valid,
    input  logic        req_ready,
    output logic [31:0] req_pc,
    input  logic        resp_valid,
    input  logic [31:0] resp_instr,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        dec_valid,
    input  logic        dec_ready,
    output logic [31:0] dec_instr,
    output logic [31:0] dec_pc,
    output logic        resp_err
);

    localparam int IW = $clog2(DEPTH);

    if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_depth_check
        $error("fetch_buffer: DEPTH must be a power of 2 and at least 2");
    end

    rv32i_word     pc_q;
    logic          live_q;
    fb_entry_t     mem [DEPTH];
    logic [IW-1:0] alloc_idx, fill_idx, head_idx;
    logic          can_req, has_head, fill_we, req_fire, pop;

    assign req_valid = live_q & can_req & ~redirect_valid;
    assign dec_valid = live_q & has_head & ~redirect_valid;
    assign req_fire  = req_valid & req_ready;
    assign pop       = dec_valid & dec_ready;
    assign req_pc    = pc_q;
    assign dec_instr = mem[head_idx].instr;
    assign dec_pc    = mem[head_idx].pc;

    fb_ptr_ctrl #(.DEPTH(DEPTH)) u_ptr (
        .clk       (clk),
        .rst_n     (rst_n),
        .redirect  (redirect_valid),
        .req_fire  (req_fire),
        .resp_valid(resp_valid),
        .pop       (pop),
        .alloc_idx (alloc_idx),
        .fill_idx  (fill_idx),
        .head_idx  (head_idx),
        .can_req   (can_req),
        .has_head  (has_head),
        .fill_we   (fill_we),
        .resp_err  (resp_err)
    );

    // Fetch PC advances per accepted request; live_q holds off traffic for the first cycle out of reset
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_q   <= RESET_PC;
            live_q <= 1'b0;
        end else begin
            live_q <= 1'b1;
            if (redirect_valid) pc_q <= word_align(redirect_pc);
            else if (req_fire)  pc_q <= pc_q + 32'd4;
        end
    end

    // Entry storage is unreset; pointers decide which slots hold meaningful data
    always_ff @(posedge clk) begin
        if (req_fire) mem[alloc_idx].pc <= pc_q;
        if (fill_we)  mem[fill_idx].instr <= resp_instr;
    end

endmodule

// File: tb/tb_fetch_buffer.sv
// tb_fetch_buffer: directed checks of fetch ordering, full-buffer backpressure, redirect drops and resp_err
module tb_fetch_buffer;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req_valid, req_ready;
    logic [31:0] req_pc;
    logic        resp_valid;
    logic [31:0] resp_instr;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        dec_valid, dec_ready;
    logic [31:0] dec_instr, dec_pc;
    logic        resp_err;

    int checks = 0;
    int errors = 0;
    int nfire  = 0;
    bit auto_cache = 1'b0;

    fetch_buffer dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .req_valid     (req_valid),
        .req_ready     (req_ready),
        .req_pc        (req_pc),
        .resp_valid    (resp_valid),
        .resp_instr    (resp_instr),
        .redirect_valid(redirect_valid),
        .redirect_pc   (redirect_pc),
        .dec_valid     (dec_valid),
        .dec_ready     (dec_ready),
        .dec_instr     (dec_instr),
        .dec_pc        (dec_pc),
        .resp_err      (resp_err)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] instr_of(input logic [31:0] pc);
        return pc ^ 32'hA5C3_0F13;
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s got %h exp %h", tag, got, exp);
        end
    endtask

    task automatic step();
        logic        f;
        logic [31:0] p;
        f = req_valid & req_ready;
        p = req_pc;
        if (f) nfire++;
        @(posedge clk);
        #1;
        resp_valid = 1'b0;
        if (auto_cache && f) begin
            resp_valid = 1'b1;
            resp_instr = instr_of(p);
        end
        #1;
    endtask

    task automatic do_reset();
        rst_n          = 1'b0;
        req_ready      = 1'b0;
        resp_valid     = 1'b0;
        resp_instr     = '0;
        redirect_valid = 1'b0;
        redirect_pc    = '0;
        dec_ready      = 1'b0;
        auto_cache     = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_req_valid", 32'(req_valid), 32'd0);
        chk("rst_dec_valid", 32'(dec_valid), 32'd0);
        chk("rst_resp_err", 32'(resp_err), 32'd0);
        rst_n = 1'b1;
        #1;
        chk("post_rst_req_valid", 32'(req_valid), 32'd0);
        @(posedge clk);
        #2;
    endtask

    initial begin
        // 1: streaming with a 1-cycle cache
        do_reset();
        auto_cache = 1'b1; req_ready = 1'b1; dec_ready = 1'b1;
        #1;
        for (int i = 0; i < 6; i++) begin
            chk("t1_req_valid", 32'(req_valid), 32'd1);
            chk("t1_req_pc", req_pc, 32'h60 + 32'(4 * i));
            if (i == 1) chk("t1_dec_valid_early", 32'(dec_valid), 32'd0);
            if (i >= 2) begin
                chk("t1_dec_valid", 32'(dec_valid), 32'd1);
                chk("t1_dec_pc", dec_pc, 32'h60 + 32'(4 * (i - 2)));
                chk("t1_dec_instr", dec_instr, instr_of(32'h60 + 32'(4 * (i - 2))));
            end
            step();
        end

        // 2: full buffer blocks requests; one pop frees exactly one slot
        do_reset();
        auto_cache = 1'b1; req_ready = 1'b1; dec_ready = 1'b0;
        #1;
        nfire = 0;
        repeat (14) step();
        chk("t2_fires", 32'(nfire), 32'd8);
        chk("t2_full_req_valid", 32'(req_valid), 32'd0);
        dec_ready = 1'b1;
        #1;
        chk("t2_head_valid", 32'(dec_valid), 32'd1);
        chk("t2_head_pc", dec_pc, 32'h60);
        step();
        dec_ready = 1'b0;
        #1;
        chk("t2_reopen_valid", 32'(req_valid), 32'd1);
        chk("t2_reopen_pc", req_pc, 32'h80);
        nfire = 0;
        repeat (4) step();
        chk("t2_one_more", 32'(nfire), 32'd1);
        chk("t2_full_again", 32'(req_valid), 32'd0);

        // 3: redirect with 3 outstanding drops the next 3 responses
        do_reset();
        req_ready = 1'b1; dec_ready = 1'b0;
        #1;
        step();
        resp_valid = 1'b1; resp_instr = instr_of(32'h60);
        step();
        step();
        step();
        #1;
        chk("t3_pre_dec_valid", 32'(dec_valid), 32'd1);
        chk("t3_pre_dec_pc", dec_pc, 32'h60);
        redirect_valid = 1'b1; redirect_pc = 32'h200;
        #1;
        chk("t3_redir_dec_valid", 32'(dec_valid), 32'd0);
        chk("t3_redir_req_valid", 32'(req_valid), 32'd0);
        step();
        redirect_valid = 1'b0; dec_ready = 1'b1;
        #1;
        chk("t3_new_req_valid", 32'(req_valid), 32'd1);
        chk("t3_new_req_pc", req_pc, 32'h200);
        resp_valid = 1'b1; resp_instr = 32'hBAD0_0001;
        step();
        req_ready = 1'b0;
        resp_valid = 1'b1; resp_instr = 32'hBAD0_0002;
        #1;
        chk("t3_drop1_dec_valid", 32'(dec_valid), 32'd0);
        step();
        resp_valid = 1'b1; resp_instr = 32'hBAD0_0003;
        #1;
        chk("t3_drop2_dec_valid", 32'(dec_valid), 32'd0);
        step();
        resp_valid = 1'b1; resp_instr = instr_of(32'h200);
        #1;
        chk("t3_drop3_dec_valid", 32'(dec_valid), 32'd0);
        step();
        chk("t3_kept_valid", 32'(dec_valid), 32'd1);
        chk("t3_kept_pc", dec_pc, 32'h200);
        chk("t3_kept_instr", dec_instr, instr_of(32'h200));
        chk("t3_resp_err", 32'(resp_err), 32'd0);

        // 4: response in the redirect cycle consumes one drop slot
        do_reset();
        req_ready = 1'b1; dec_ready = 1'b1;
        #1;
        step();
        step();
        req_ready = 1'b0;
        redirect_valid = 1'b1; redirect_pc = 32'h503;
        resp_valid = 1'b1; resp_instr = 32'hBAD0_0004;
        step();
        redirect_valid = 1'b0;
        resp_valid = 1'b1; resp_instr = 32'hBAD0_0005;
        step();
        req_ready = 1'b1;
        #1;
        chk("t4_req_pc", req_pc, 32'h500);
        step();
        req_ready = 1'b0;
        resp_valid = 1'b1; resp_instr = instr_of(32'h500);
        step();
        chk("t4_dec_valid", 32'(dec_valid), 32'd1);
        chk("t4_dec_pc", dec_pc, 32'h500);
        chk("t4_dec_instr", dec_instr, instr_of(32'h500));
        chk("t4_resp_err", 32'(resp_err), 32'd0);

        // 5: back-to-back redirects, last target wins, 2 drops total
        do_reset();
        req_ready = 1'b1; dec_ready = 1'b1;
        #1;
        step();
        step();
        redirect_valid = 1'b1; redirect_pc = 32'h300;
        step();
        redirect_valid = 1'b1; redirect_pc = 32'h400;
        step();
        redirect_valid = 1'b0;
        resp_valid = 1'b1; resp_instr = 32'hBAD0_0006;
        #1;
        chk("t5_req_pc", req_pc, 32'h400);
        step();
        resp_valid = 1'b1; resp_instr = 32'hBAD0_0007;
        step();
        req_ready = 1'b0;
        resp_valid = 1'b1; resp_instr = instr_of(32'h400);
        #1;
        chk("t5_dropping_dec_valid", 32'(dec_valid), 32'd0);
        step();
        resp_valid = 1'b1; resp_instr = instr_of(32'h404);
        #1;
        chk("t5_first_valid", 32'(dec_valid), 32'd1);
        chk("t5_first_pc", dec_pc, 32'h400);
        chk("t5_first_instr", dec_instr, instr_of(32'h400));
        step();
        chk("t5_second_valid", 32'(dec_valid), 32'd1);
        chk("t5_second_pc", dec_pc, 32'h404);
        chk("t5_second_instr", dec_instr, instr_of(32'h404));
        step();
        chk("t5_empty", 32'(dec_valid), 32'd0);
        chk("t5_resp_err", 32'(resp_err), 32'd0);

        // 6: spurious response sets sticky resp_err; async reset clears it
        do_reset();
        step();
        resp_valid = 1'b1; resp_instr = 32'hBAD0_0008;
        step();
        chk("t6_err_set", 32'(resp_err), 32'd1);
        repeat (3) step();
        chk("t6_err_sticky", 32'(resp_err), 32'd1);
        auto_cache = 1'b1; req_ready = 1'b1; dec_ready = 1'b1;
        repeat (5) step();
        chk("t6_stream_err", 32'(resp_err), 32'd1);
        rst_n = 1'b0;
        #1;
        chk("t6_async_err", 32'(resp_err), 32'd0);
        chk("t6_async_req_valid", 32'(req_valid), 32'd0);
        chk("t6_async_dec_valid", 32'(dec_valid), 32'd0);
        do_reset();
        req_ready = 1'b1;
        #1;
        chk("t6_restart_valid", 32'(req_valid), 32'd1);
        chk("t6_restart_pc", req_pc, 32'h60);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
